// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Iteration counter counts WIDTH-1 down to 0.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/intf_seq_divider.sv
// Signal bundle connecting the divider to its surroundings.
interface intf_seq_divider #(
    parameter int WIDTH = 8
) (
    input logic clk
);
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport ctrl (output rst, start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/nbit_subtractor.sv
// Combinational N-bit ripple subtractor: diff = a + ~b + 1.
module nbit_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic nb;
        assign nb           = ~b[i];
        assign diff[i]      = a[i] ^ nb ^ carry[i];
        assign carry[i+1]   = (a[i] & nb) | (carry[i] & (a[i] ^ nb));
    end

    assign borrow = ~carry[N];
endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_restoring_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             sub_borrow_unused;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Partial remainder stays below the divisor, so |trial| < 2^WIDTH and the MSB is its sign.
    assign shifted = {rem_q, quo_q[WIDTH-1]};

    nbit_subtractor #(.N(WIDTH + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, dvsr_q}),
        .diff   (trial),
        .borrow (sub_borrow_unused)
    );

    assign trial_ok = ~trial[WIDTH];
    assign rem_nxt  = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_nxt  = {quo_q[WIDTH-2:0], trial_ok};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic quo_neg;
    logic rem_neg;

    assign a_mag   = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag   = divisor[WIDTH-1]  ? -divisor  : divisor;
    // The -2^(W-1) / -1 case wraps back to -2^(W-1) naturally.
    assign quo_fix = quo_neg ? -quo_nxt : quo_nxt;
    assign rem_fix = rem_neg ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else if (state == IDLE && start) begin
            quo_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rem_neg <= dividend[WIDTH-1];
        end
    end
`else
    assign a_mag   = dividend;
    assign b_mag   = divisor;
    assign quo_fix = quo_nxt;
    assign rem_fix = rem_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvsr_q <= b_mag;
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            rem_q <= '0;
                            quo_q <= a_mag;
                            cnt   <= CW'(WIDTH - 1);
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (cnt == '0) begin
                        state       <= DONE;
                        quotient    <= quo_fix;
                        remainder   <= rem_fix;
                        div_by_zero <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (WIDTH=8).
module tb_seq_restoring_divider;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    intf_seq_divider #(.WIDTH(W)) bus (.clk(clk));

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (bus.clk),
        .rst         (bus.rst),
        .start       (bus.start),
        .dividend    (bus.dividend),
        .divisor     (bus.divisor),
        .busy        (bus.busy),
        .done        (bus.done),
        .quotient    (bus.quotient),
        .remainder   (bus.remainder),
        .div_by_zero (bus.div_by_zero)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Drive a start pulse that is accepted at the next rising edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Returns cycle index of done after the accepting edge (-1 on timeout) and busy cycles seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input int lat, input int lat_exp,
                                input logic [W-1:0] q_exp, input logic [W-1:0] r_exp,
                                input logic z_exp);
        n_cmp++;
        if (lat !== lat_exp) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, lat_exp);
        end
        n_cmp++;
        if (bus.quotient !== q_exp) begin
            n_err++;
            $display("FAIL %s quotient: got %h want %h", name, bus.quotient, q_exp);
        end
        n_cmp++;
        if (bus.remainder !== r_exp) begin
            n_err++;
            $display("FAIL %s remainder: got %h want %h", name, bus.remainder, r_exp);
        end
        n_cmp++;
        if (bus.div_by_zero !== z_exp) begin
            n_err++;
            $display("FAIL %s div_by_zero: got %b want %b", name, bus.div_by_zero, z_exp);
        end
    endtask

    task automatic test_reset();
        bus.rst      = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        n_cmp++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h z=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        bus.rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        start_op(8'd100, 8'd7);
        wait_done(lat, bcnt);
        check_result("div_100_7", lat, 9, 8'd14, 8'd2, 1'b0);
        n_cmp++;
        if (bcnt !== 9) begin
            n_err++;
            $display("FAIL busy_cycles: got %0d want 9", bcnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a_v [3] = '{8'd255, 8'd5, 8'd0};
        logic [W-1:0] b_v [3] = '{8'd1,   8'd9, 8'd3};
        logic [W-1:0] q_v [3] = '{8'd255, 8'd0, 8'd0};
        logic [W-1:0] r_v [3] = '{8'd0,   8'd5, 8'd0};
        int lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            start_op(a_v[i], b_v[i]);
            wait_done(lat, bcnt);
            check_result($sformatf("b2b_%0d", i), lat, 9, q_v[i], r_v[i], 1'b0);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_done: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        start_op(8'd37, 8'd0);
        wait_done(lat, bcnt);
        check_result("div_37_0", lat, 1, 8'hFF, 8'd37, 1'b1);
        start_op(8'd200, 8'd10);
        wait_done(lat, bcnt);
        check_result("div_200_10", lat, 9, 8'd20, 8'd0, 1'b0);
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        int extra = 0;
        start_op(8'd100, 8'd7);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 3) begin
                bus.dividend = 8'd50;
                bus.divisor  = 8'd5;
                bus.start    = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check_result("ignore_start", lat, 9, 8'd14, 8'd2, 1'b0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL no_second_done: got %0d done pulses want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        int seen = 0;
        start_op(8'd100, 8'd7);
        repeat (4) @(negedge clk);
        bus.rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h z=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        bus.rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abandoned_op: got %0d busy/done cycles want 0", seen);
        end
        start_op(8'd81, 8'd9);
        wait_done(lat, bcnt);
        check_result("div_81_9", lat, 9, 8'd9, 8'd0, 1'b0);
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed();
        int lat, bcnt;
        start_op(8'h9C, 8'd7);          // -100 / 7
        wait_done(lat, bcnt);
        check_result("s_m100_7", lat, 9, 8'hF2, 8'hFE, 1'b0);
        start_op(8'd100, 8'hF9);        // 100 / -7
        wait_done(lat, bcnt);
        check_result("s_100_m7", lat, 9, 8'hF2, 8'h02, 1'b0);
        start_op(8'h80, 8'hFF);         // -128 / -1
        wait_done(lat, bcnt);
        check_result("s_m128_m1", lat, 9, 8'h80, 8'h00, 1'b0);
        start_op(8'hF6, 8'd0);          // -10 / 0
        wait_done(lat, bcnt);
        check_result("s_div_zero", lat, 1, 8'hFF, 8'hF6, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
